// File: rtl/w_mem_banked_ctrl_pkg.sv
// Shared constants and types for the banked weight-memory controller.
package w_mem_banked_ctrl_pkg;

   localparam int ARB_WRITE_PRIO  = 0;
   localparam int ARB_ROUND_ROBIN = 1;

   localparam int LANE_W_DEF = 8;
   localparam int LANES_DEF  = 4;

   typedef logic signed [LANE_W_DEF-1:0] lane_t;
   typedef lane_t [LANES_DEF-1:0]        lane_row_t;

   function automatic bit is_pow2(input int n);
      return (n > 0) && ((n & (n - 1)) == 0);
   endfunction

endpackage

// File: rtl/SRAM_parametrizable_w_equivalent.sv
// Behavioural equivalent of the single-port weight SRAM macro: active-low
// chip/write enables, registered read data, contents untouched by reset.
module SRAM_parametrizable_w_equivalent #(
   parameter int numWord = 1024,
   parameter int numBit  = 32
) (
   input  logic                       CLK,
   input  logic                       CEB,
   input  logic                       WEB,
   input  logic [$clog2(numWord)-1:0] A,
   input  logic [numBit-1:0]          D,
   output logic [numBit-1:0]          Q,
   input  logic                       scan_en_in
);

   logic [numBit-1:0] mem [numWord];

   // Functional accesses are suppressed while the scan chain is shifting.
   always_ff @(posedge CLK) begin
      if (!CEB && !scan_en_in) begin
         if (!WEB) mem[A] <= D;
         else      Q      <= mem[A];
      end
   end

endmodule

// File: rtl/w_mem_banked_ctrl_rd_fifo.sv
// Read-return FIFO: synchronous, any depth >= 2, push and pop may coincide at
// any occupancy.
module w_mem_rd_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full, do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign do_pop  = pop_i & (count_q != '0);
   // When full, the incoming word lands in the slot the popped head vacates.
   assign do_push = push_i & (~full | do_pop);

   always_comb begin
      wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/w_mem_banked_ctrl.sv
// Banked weight-memory controller: independent read/write ports over BANKS
// columns of SRAM macros, same-bank arbitration and a credited read FIFO.
module w_mem_banked_ctrl
   import w_mem_banked_ctrl_pkg::*;
#(
   parameter  int LANES          = 4,
   parameter  int LANE_W         = 8,
   parameter  int BANKS          = 2,
   parameter  int BANK_DEPTH     = 1024,
   parameter  int MACRO_W        = 32,
   parameter  int ARB_MODE       = ARB_WRITE_PRIO,
   parameter  int RD_FIFO_DEPTH  = 2,
   localparam int ROW_W          = $clog2(BANK_DEPTH),
   localparam int BANK_W         = (BANKS > 1) ? $clog2(BANKS) : 1,
   localparam int ADDR_W         = ROW_W + $clog2(BANKS),
   localparam int DATA_W         = LANES * LANE_W,
   localparam int MACROS_PER_ROW = DATA_W / MACRO_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              scan_en_in,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_valid,
   output logic              rd_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_data_valid,
   input  logic              rd_data_ready
);

   localparam int CNT_W = $clog2(RD_FIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;
   localparam bit RR_EN = (ARB_MODE == ARB_ROUND_ROBIN);

   if (!is_pow2(BANKS)) begin : g_err_banks
      $error("w_mem_banked_ctrl: BANKS must be a power of two");
   end
   if (!is_pow2(BANK_DEPTH)) begin : g_err_depth
      $error("w_mem_banked_ctrl: BANK_DEPTH must be a power of two");
   end
   if ((DATA_W % MACRO_W) != 0) begin : g_err_macro
      $error("w_mem_banked_ctrl: LANES*LANE_W must be a multiple of MACRO_W");
   end
   if (RD_FIFO_DEPTH < 2) begin : g_err_fifo
      $error("w_mem_banked_ctrl: RD_FIFO_DEPTH must be at least 2");
   end
   if (ARB_MODE != ARB_WRITE_PRIO && ARB_MODE != ARB_ROUND_ROBIN) begin : g_err_arb
      $error("w_mem_banked_ctrl: unknown ARB_MODE");
   end

   logic [BANK_W-1:0] wr_bank, rd_bank;
   logic [ROW_W-1:0]  wr_row, rd_row;

   assign wr_row = wr_addr[ROW_W-1:0];
   assign rd_row = rd_addr[ROW_W-1:0];

   if (BANKS > 1) begin : g_bank_dec
      assign wr_bank = wr_addr[ADDR_W-1:ROW_W];
      assign rd_bank = rd_addr[ADDR_W-1:ROW_W];
   end else begin : g_bank_one
      assign wr_bank = '0;
      assign rd_bank = '0;
   end

   logic              inflight_q, inflight_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
   logic [CNT_W-1:0]  fifo_count;
   logic [OCC_W-1:0]  occ_next;
   logic              pop, credit_ok, rd_req, conflict, read_wins;
   logic              wr_fire, rd_fire;

   // Occupancy the FIFO will have after this edge; a read accepted now lands
   // one cycle later, so it needs a free slot against that figure.
   assign pop       = rd_data_valid & rd_data_ready;
   assign occ_next  = {1'b0, fifo_count} + OCC_W'(inflight_q) - OCC_W'(pop);
   assign credit_ok = (occ_next < OCC_W'(RD_FIFO_DEPTH));

   // A read without credit cannot be granted, so it never blocks the write.
   assign rd_req    = rd_valid & credit_ok;
   assign conflict  = wr_valid & rd_req & (wr_bank == rd_bank);
   assign read_wins = RR_EN & rr_ptr_q;

   assign wr_ready = reset & ~(conflict & read_wins);
   assign rd_ready = reset & credit_ok & ~(conflict & ~read_wins);
   assign wr_fire  = wr_valid & wr_ready;
   assign rd_fire  = rd_valid & rd_ready;

   always_comb begin
      rr_ptr_d   = (RR_EN && conflict) ? ~rr_ptr_q : rr_ptr_q;
      inflight_d = rd_fire;
      rd_bank_d  = rd_fire ? rd_bank : rd_bank_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         inflight_q <= 1'b0;
         rr_ptr_q   <= 1'b0;
         rd_bank_q  <= '0;
      end else begin
         inflight_q <= inflight_d;
         rr_ptr_q   <= rr_ptr_d;
         rd_bank_q  <= rd_bank_d;
      end
   end

   logic [BANKS-1:0]             bank_ceb, bank_web;
   logic [BANKS-1:0][ROW_W-1:0]  bank_a;
   logic [BANKS-1:0][DATA_W-1:0] bank_d, bank_q;

   always_comb begin
      bank_ceb = '1;
      bank_web = '1;
      bank_a   = '0;
      bank_d   = '0;
      for (int b = 0; b < BANKS; b++) begin
         if (wr_fire && wr_bank == BANK_W'(b)) begin
            bank_ceb[b] = 1'b0;
            bank_web[b] = 1'b0;
            bank_a[b]   = wr_row;
            bank_d[b]   = wr_data;
         end else if (rd_fire && rd_bank == BANK_W'(b)) begin
            bank_ceb[b] = 1'b0;
            bank_a[b]   = rd_row;
         end
      end
   end

   for (genvar b = 0; b < BANKS; b++) begin : g_bank
      for (genvar m = 0; m < MACROS_PER_ROW; m++) begin : g_mac
         SRAM_parametrizable_w_equivalent #(
            .numWord (BANK_DEPTH),
            .numBit  (MACRO_W)
         ) u_mac (
            .CLK        (clk),
            .CEB        (bank_ceb[b]),
            .WEB        (bank_web[b]),
            .A          (bank_a[b]),
            .D          (bank_d[b][m*MACRO_W +: MACRO_W]),
            .Q          (bank_q[b][m*MACRO_W +: MACRO_W]),
            .scan_en_in (scan_en_in)
         );
      end
   end

   logic [DATA_W-1:0] rd_q;
   assign rd_q = bank_q[rd_bank_q];

   w_mem_rd_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (RD_FIFO_DEPTH)
   ) u_rd_fifo (
      .clk         (clk),
      .reset       (reset),
      .push_i      (inflight_q),
      .push_data_i (rd_q),
      .pop_i       (pop),
      .head_o      (rd_data),
      .valid_o     (rd_data_valid),
      .count_o     (fifo_count)
   );

endmodule
